// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_adder.sv
// One-bit full adder built from two half adders.
// Ports:
//   a, b, cin : addend bits and carry in
//   sum       : a ^ b ^ cin
//   c         : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic c
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  // First half adder: a + b
  assign ha0_s = a ^ b;
  assign ha0_c = a & b;

  // Second half adder: partial sum + cin
  assign sum   = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;

  assign c = ha0_c | ha1_c;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b (mod 2^WIDTH),
// computed LSB first as a + ~b + 1 through a single full-adder cell.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   start  : request, sampled only in IDLE (a and b captured with it)
//   a, b   : minuend / subtrahend
//   diff   : result, held until the next completion
//   borrow : 1 when a < b (unsigned), held with diff
//   busy   : high while in RUN
//   done   : one-cycle pulse when diff/borrow are newly valid
//
// Handshake: a request is accepted on the rising edge where start=1 and the
// block is idle (busy=0, done=0); start at any other time is dropped, not
// queued. Exactly one done pulse follows each accepted request, WIDTH+1
// cycles after the accepting edge, unless reset intervenes.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    count;
  logic             carry;
  logic             fa_sum;
  logic             fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] r_next;

  full_adder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .sum (fa_sum),
    .c   (fa_c)
  );

  assign last_bit = (count == LAST_BIT);
  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign r_next   = {fa_sum, r_sh[WIDTH-1:1]};

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      count  <= '0;
      carry  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= ~b;
            carry <= 1'b1;   // the +1 of two's-complement negation
            count <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_next;
          carry <= fa_c;
          if (last_bit) begin
            diff   <= r_next;
            borrow <= ~fa_c;  // no carry out of the MSB means a < b
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
